// File: rtl/scale_pipe.sv
// scale_pipe: 3-stage display->source address scaler with per-axis power-of-two zoom.
// Build option SCALE_CENTER_EN centres the scaled image; undefined leaves it top-left.
module scale_pipe #(
    parameter int SRC_W    = 240,
    parameter int SRC_H    = 320,
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int SIDE_W   = 3,
    parameter int ADDR_W   = $clog2(SRC_W*SRC_H)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [1:0]        hs_shift_in,
    input  logic [1:0]        vs_shift_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic [SIDE_W-1:0] side_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              valid_addr_out,
    output logic [SIDE_W-1:0] side_out,
    output logic [1:0]        hs_active_out,
    output logic [1:0]        vs_active_out,
    output logic              update_pend_out
);
    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

    logic       frame_start;
    logic [1:0] hs_act, vs_act, hs_eff, vs_eff;
    logic [11:0] hoff, voff;

    assign frame_start = (hcount_in == '0) && (vcount_in == '0);
    // The frame-start pixel itself must already see the newly requested shifts.
    assign hs_eff = frame_start ? hs_shift_in : hs_act;
    assign vs_eff = frame_start ? vs_shift_in : vs_act;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hs_act          <= '0;
            vs_act          <= '0;
            update_pend_out <= 1'b0;
        end else begin
            if (frame_start) begin
                hs_act <= hs_shift_in;
                vs_act <= vs_shift_in;
            end
            update_pend_out <= (hs_shift_in != hs_act) || (vs_shift_in != vs_act);
        end
    end

    assign hs_active_out = hs_act;
    assign vs_active_out = vs_act;

`ifdef SCALE_CENTER_EN
    function automatic logic [11:0] centre_off(input int active, input int src, input logic [1:0] s);
        int d;
        d = active - (src << s);
        if (d < 0) d = 0;
        return 12'(d / 2);
    endfunction

    assign hoff = centre_off(H_ACTIVE, SRC_W, hs_eff);
    assign voff = centre_off(V_ACTIVE, SRC_H, vs_eff);
`else
    assign hoff = '0;
    assign voff = '0;
`endif

    // Stage 1: offset-corrected coordinates, carrying the shifts the pixel was latched with.
    logic signed [11:0] h_c, v_c, s1_h, s1_v;
    logic               act_c, s1_act;
    logic [1:0]         s1_hs, s1_vs;
    logic [SIDE_W-1:0]  s1_side;

    assign h_c   = $signed({1'b0, hcount_in}) - $signed(hoff);
    assign v_c   = $signed({2'b0, vcount_in}) - $signed(voff);
    assign act_c = (hcount_in < H_LIM) && (vcount_in < V_LIM);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_h    <= '0;
            s1_v    <= '0;
            s1_act  <= 1'b0;
            s1_hs   <= '0;
            s1_vs   <= '0;
            s1_side <= '0;
        end else begin
            s1_h    <= h_c;
            s1_v    <= v_c;
            s1_act  <= act_c;
            s1_hs   <= hs_eff;
            s1_vs   <= vs_eff;
            s1_side <= side_in;
        end
    end

    // Stage 2: bounds test against the scaled extent, then downscale and row multiply.
    logic [13:0]       lim_h, lim_v;
    logic              in_c, s2_in;
    logic [ADDR_W-1:0] col_c, row_c, prod_c, s2_col, s2_prod;
    logic [SIDE_W-1:0] s2_side;

    assign lim_h  = 14'(SRC_W) << s1_hs;
    assign lim_v  = 14'(SRC_H) << s1_vs;
    assign in_c   = s1_act && !s1_h[11] && !s1_v[11]
                    && ({3'b0, s1_h[10:0]} < lim_h) && ({3'b0, s1_v[10:0]} < lim_v);
    assign col_c  = ADDR_W'(s1_h[10:0] >> s1_hs);
    assign row_c  = ADDR_W'(s1_v[10:0] >> s1_vs);
    assign prod_c = row_c * ADDR_W'(SRC_W);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s2_in   <= 1'b0;
            s2_col  <= '0;
            s2_prod <= '0;
            s2_side <= '0;
        end else begin
            s2_in   <= in_c;
            s2_col  <= col_c;
            s2_prod <= prod_c;
            s2_side <= s1_side;
        end
    end

    // Stage 3: out-of-image pixels present address 0 rather than a wrapped value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr_out       <= '0;
            valid_addr_out <= 1'b0;
            side_out       <= '0;
        end else begin
            addr_out       <= s2_in ? (s2_prod + s2_col) : '0;
            valid_addr_out <= s2_in;
            side_out       <= s2_side;
        end
    end

endmodule

// File: tb/tb_scale_pipe.sv
// tb_scale_pipe: randomized and directed stimulus for scale_pipe against an arithmetic reference model.
// Honours SCALE_CENTER_EN the same way as the design build.
module tb_scale_pipe;
    localparam int SRC_W    = 240;
    localparam int SRC_H    = 320;
    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;
    localparam int SIDE_W   = 3;
    localparam int ADDR_W   = 17;
    localparam int EW       = 1 + SIDE_W + ADDR_W;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic [1:0]        hs_shift_in = '0;
    logic [1:0]        vs_shift_in = '0;
    logic [10:0]       hcount_in = '0;
    logic [9:0]        vcount_in = '0;
    logic [SIDE_W-1:0] side_in = '0;
    logic [ADDR_W-1:0] addr_out;
    logic              valid_addr_out;
    logic [SIDE_W-1:0] side_out;
    logic [1:0]        hs_active_out;
    logic [1:0]        vs_active_out;
    logic              update_pend_out;

    scale_pipe dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .hs_shift_in     (hs_shift_in),
        .vs_shift_in     (vs_shift_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .side_in         (side_in),
        .addr_out        (addr_out),
        .valid_addr_out  (valid_addr_out),
        .side_out        (side_out),
        .hs_active_out   (hs_active_out),
        .vs_active_out   (vs_active_out),
        .update_pend_out (update_pend_out)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0] exp_q[$];
    int m_hs, m_vs;
    int req_hs, req_vs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the pixel's source address from the scaling rules, in plain integer arithmetic.
    function automatic logic [EW-1:0] model(input int hc, input int vc, input int hs, input int vs, input int sd);
        int  ho, vo, h, v, a;
        bit  in;
        ho = 0;
        vo = 0;
`ifdef SCALE_CENTER_EN
        ho = H_ACTIVE - (SRC_W << hs);
        vo = V_ACTIVE - (SRC_H << vs);
        if (ho < 0) ho = 0;
        if (vo < 0) vo = 0;
        ho = ho / 2;
        vo = vo / 2;
`endif
        h  = hc - ho;
        v  = vc - vo;
        in = (hc < H_ACTIVE) && (vc < V_ACTIVE) && (h >= 0) && (v >= 0)
             && (h < (SRC_W << hs)) && (v < (SRC_H << vs));
        a  = in ? (v / (1 << vs)) * SRC_W + (h / (1 << hs)) : 0;
        return {in, SIDE_W'(sd), ADDR_W'(a)};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        m_hs = 0;
        m_vs = 0;
    endtask

    // driver: one pixel per clock, then scoreboard every output
    task automatic drive(input int hc, input int vc, input int hsr, input int vsr, input int sd);
        logic [EW-1:0] e;
        bit            pend;
        hcount_in   = 11'(hc);
        vcount_in   = 10'(vc);
        hs_shift_in = 2'(hsr);
        vs_shift_in = 2'(vsr);
        side_in     = SIDE_W'(sd);
        @(posedge clk_in);
        pend = (hsr != m_hs) || (vsr != m_vs);
        if (hc == 0 && vc == 0) begin
            m_hs = hsr;
            m_vs = vsr;
        end
        exp_q.push_back(model(hc, vc, m_hs, m_vs, sd));
        #1;
        e = exp_q.pop_front();
        check("addr", 32'(addr_out), 32'(e[ADDR_W-1:0]));
        check("valid", 32'(valid_addr_out), 32'(e[EW-1]));
        check("side", 32'(side_out), 32'(e[EW-2:ADDR_W]));
        check("hs_active", 32'(hs_active_out), 32'(m_hs));
        check("vs_active", 32'(vs_active_out), 32'(m_vs));
        check("update_pend", 32'(update_pend_out), 32'(pend));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, 32'(addr_out), 0);
        check({tag, "_valid"}, 32'(valid_addr_out), 0);
        check({tag, "_side"}, 32'(side_out), 0);
        check({tag, "_hs_active"}, 32'(hs_active_out), 0);
        check({tag, "_vs_active"}, 32'(vs_active_out), 0);
        check({tag, "_pend"}, 32'(update_pend_out), 0);
    endtask

    initial begin
        int row0;
        repeat (3) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();

`ifndef SCALE_CENTER_EN
        // right/bottom edge of the 1x image
        drive(0, 0, 0, 0, 0);
        drive(239, 319, 0, 0, 0);
        drive(240, 319, 0, 0, 0);
        drive(0, 500, 0, 0, 0);
        check("t1_addr_max", 32'(addr_out), 76799);
        check("t1_valid", 32'(valid_addr_out), 1);
        drive(1, 500, 0, 0, 0);
        check("t1_past_edge_valid", 32'(valid_addr_out), 0);
        check("t1_past_edge_addr", 32'(addr_out), 0);

        // 4x/2x zoom edge
        drive(0, 0, 2, 1, 0);
        drive(959, 639, 2, 1, 0);
        drive(960, 639, 2, 1, 0);
        drive(0, 700, 2, 1, 0);
        check("t2_addr_max", 32'(addr_out), 76799);
        check("t2_valid", 32'(valid_addr_out), 1);
        drive(1, 700, 2, 1, 0);
        check("t2_past_edge_valid", 32'(valid_addr_out), 0);
`else
        // centred 4x/2x: image starts at (160,40)
        drive(0, 0, 2, 1, 0);
        drive(160, 40, 2, 1, 0);
        drive(159, 40, 2, 1, 0);
        drive(0, 600, 2, 1, 0);
        check("t6_origin_addr", 32'(addr_out), 0);
        check("t6_origin_valid", 32'(valid_addr_out), 1);
        drive(1, 600, 2, 1, 0);
        check("t6_left_of_origin_valid", 32'(valid_addr_out), 0);
`endif

        // mid-frame request is deferred to the next frame start
        drive(0, 0, 0, 0, 0);
        drive(500, 100, 2, 0, 0);
        check("t3_hs_held", 32'(hs_active_out), 0);
        check("t3_pend_set", 32'(update_pend_out), 1);
        drive(501, 100, 2, 0, 0);
        check("t3_hs_still_held", 32'(hs_active_out), 0);
        drive(0, 0, 2, 0, 0);
        check("t3_hs_loaded", 32'(hs_active_out), 2);
        drive(1, 0, 2, 0, 0);
        check("t3_pend_clear", 32'(update_pend_out), 0);

        // sideband alignment
        drive(5, 5, 2, 0, 5);
        drive(6, 5, 2, 0, 0);
        drive(7, 5, 2, 0, 0);
        check("t4_side_lat3", 32'(side_out), 5);

        // continuous scans: random zoom per frame, mid-row request changes
        for (int f = 0; f < 12; f++) begin
            req_hs = $urandom_range(0, 3);
            req_vs = $urandom_range(0, 3);
            drive(0, 0, req_hs, req_vs, $urandom_range(0, 7));
            row0 = $urandom_range(0, 748);
            for (int r = 0; r < 2; r++) begin
                for (int hc = 0; hc < 1650; hc++) begin
                    if (r == 0 && hc == 800) begin
                        req_hs = $urandom_range(0, 3);
                        req_vs = $urandom_range(0, 3);
                    end
                    drive(hc, row0 + r, req_hs, req_vs, $urandom_range(0, 7));
                end
            end
        end

        // scattered pixels with occasional frame starts
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                req_hs = $urandom_range(0, 3);
                req_vs = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 39) == 0)
                drive(0, 0, req_hs, req_vs, $urandom_range(0, 7));
            else
                drive($urandom_range(0, 2047), $urandom_range(0, 1023), req_hs, req_vs, $urandom_range(0, 7));
        end

        // asynchronous reset while a valid address is showing
        drive(0, 0, 3, 3, 0);
        drive(640, 360, 3, 3, 7);
        drive(641, 360, 3, 3, 0);
        drive(642, 360, 3, 3, 0);
        check("t5_pre_reset_valid", 32'(valid_addr_out), 1);
        #2;
        rst_in = 1'b1;
        #1;
        check_all_zero("t5_async");
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        drive(10, 10, 0, 0, 0);
        check("t5_hs_after_reset", 32'(hs_active_out), 0);
        drive(11, 10, 0, 0, 0);
        drive(12, 10, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
